vfifo_sc_fifo_ctrl: RTL and testbench

Single-clock FIFO controller placed directly upstream of vfifo_dual_port_ram_sc_sw.
- Drives the RAM write port (adr_a, we_a) and read address (adr_b).
- Generates full, empty, almost-full, almost-empty and fill count.
- The RAM registers adr_b, so the controller presents the next read address one cycle early. q_b therefore always shows the head entry (first-word-fall-through).
- Write data goes straight to RAM d_a; q_b is the FIFO output.

---
 rtl/vfifo_pkg.sv | 36 +++
 rtl/vfifo_ptr_cnt.sv | 35 +++
 rtl/vfifo_sc_fifo_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_vfifo_sc_fifo_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfifo_pkg.sv
// -----------------------------------------------------------------------------
// vfifo_pkg
// Shared definitions for the vfifo single-clock FIFO controller slice.
//   DEFAULT_ADDR_WIDTH : default RAM address width of the FIFO
//   DEFAULT_DEPTH      : entries held at the default address width
//   xfer_e             : accepted-transfer classification {write, read}
//   clog2()            : ceiling log2 for sizing counters and pointers
// -----------------------------------------------------------------------------
package vfifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 1 << DEFAULT_ADDR_WIDTH;

  // Encoding is {write accepted, read accepted} so a concatenation of the
  // two accept strobes casts straight onto it.
  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_RD   = 2'b01,
    XFER_WR   = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vfifo_ptr_cnt.sv
// -----------------------------------------------------------------------------
// vfifo_ptr_cnt
// Wrapping binary pointer with increment enable. The incremented value is
// exported so the parent can look one entry ahead without a second adder.
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active-low
//   en      : advance the pointer at the next rising edge
//   ptr     : current pointer value (registered)
//   ptr_inc : ptr + 1, modulo 2**WIDTH (combinational)
// -----------------------------------------------------------------------------
module vfifo_ptr_cnt #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] ptr,
  output logic [WIDTH-1:0] ptr_inc
);

  logic [WIDTH-1:0] ptr_reg;

  // Natural overflow of the adder provides the wrap from all-ones to zero.
  assign ptr_inc = ptr_reg + WIDTH'(1);
  assign ptr     = ptr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= '0;
    end else if (en) begin
      ptr_reg <= ptr_inc;
    end
  end

endmodule

// File: rtl/vfifo_sc_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// vfifo_sc_fifo_ctrl
// Single-clock FIFO controller sitting in front of a dual-port RAM that
// registers its read address. The read address is presented one cycle early
// so the RAM output always shows the head entry (first-word-fall-through).
//
// Ports:
//   clk          : sole clock, rising edge
//   rst          : asynchronous reset, active-low
//   wr_en        : push request (write data goes straight to the RAM)
//   rd_en        : pop request (head word is on the RAM output this cycle)
//   full         : occupancy == 2**ADDR_WIDTH
//   empty        : occupancy == 0
//   almost_full  : fill_cnt >= AFULL_LVL
//   almost_empty : fill_cnt <= AEMPTY_LVL
//   fill_cnt     : current occupancy, 0..2**ADDR_WIDTH
//   adr_a        : RAM write address
//   we_a         : RAM write enable = accepted push
//   adr_b        : RAM read address for the head after this edge
//   ovf_err      : sticky, push attempted while full   (VFIFO_ERR_FLAGS_EN)
//   udf_err      : sticky, pop attempted while empty   (VFIFO_ERR_FLAGS_EN)
//
// Build option: define VFIFO_ERR_FLAGS_EN to add the sticky error outputs.
// -----------------------------------------------------------------------------
module vfifo_sc_fifo_ctrl
  import vfifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_LVL  = (2**ADDR_WIDTH) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_cnt,
  output logic [ADDR_WIDTH-1:0] adr_a,
  output logic                  we_a,
  output logic [ADDR_WIDTH-1:0] adr_b
`ifdef VFIFO_ERR_FLAGS_EN
  ,
  output logic                  ovf_err,
  output logic                  udf_err
`endif
);

  localparam int PTR_W  = ADDR_WIDTH + 1;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int WR_IDX = 0;
  localparam int RD_IDX = 1;

  localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_LVL);
  localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_LVL);
  localparam logic [PTR_W-1:0] ONE_C    = PTR_W'(1);

  // ---------------------------------------------------------------------------
  // Accept logic. Flags are registered, so there is no combinational path
  // from the requests to full/empty. The write strobe is also held low while
  // reset is asserted so nothing reaches the RAM during reset.
  // ---------------------------------------------------------------------------
  logic  wr_acc;
  logic  rd_acc;
  xfer_e xfer;

  assign wr_acc = wr_en & ~full & rst;
  assign rd_acc = rd_en & ~empty;
  assign xfer   = xfer_e'({wr_acc, rd_acc});

  // ---------------------------------------------------------------------------
  // Write and read pointers: same counter, index 0 = write, index 1 = read.
  // ---------------------------------------------------------------------------
  logic [1:0]       ptr_en;
  logic [PTR_W-1:0] ptr_q   [2];
  logic [PTR_W-1:0] ptr_inc [2];

  assign ptr_en[WR_IDX] = wr_acc;
  assign ptr_en[RD_IDX] = rd_acc;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ptr
      vfifo_ptr_cnt #(
        .WIDTH (PTR_W)
      ) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .en      (ptr_en[gi]),
        .ptr     (ptr_q[gi]),
        .ptr_inc (ptr_inc[gi])
      );
    end
  endgenerate

  assign adr_a = ptr_q[WR_IDX][ADDR_WIDTH-1:0];
  assign we_a  = wr_acc;

  // The RAM captures adr_b at the edge that also commits the pop, so after
  // that edge its internal address equals the new read pointer and the RAM
  // output already shows the next head. A push to the current head slot is
  // written at that same edge, so it is visible right after it as well.
  assign adr_b = rd_acc ? ptr_inc[RD_IDX][ADDR_WIDTH-1:0]
                        : ptr_q[RD_IDX][ADDR_WIDTH-1:0];

  // The wrap bits and the write-side look-ahead are not needed by this
  // controller; occupancy is tracked by a dedicated counter instead.
  logic unused_ptr_bits;
  assign unused_ptr_bits = ^{ptr_q[WR_IDX][ADDR_WIDTH], ptr_q[RD_IDX][ADDR_WIDTH],
                             ptr_inc[WR_IDX], ptr_inc[RD_IDX][ADDR_WIDTH]};

  // ---------------------------------------------------------------------------
  // Occupancy counter and status flags. Flags are computed from the next count
  // and registered, which makes them identical to decoding the registered
  // count while keeping the outputs straight off flops.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] fill_cnt_reg;
  logic [PTR_W-1:0] fill_cnt_next;
  logic             full_reg;
  logic             empty_reg;
  logic             almost_full_reg;
  logic             almost_empty_reg;

  always_comb begin
    fill_cnt_next = fill_cnt_reg;
    case (xfer)
      XFER_WR: fill_cnt_next = fill_cnt_reg + ONE_C;
      XFER_RD: fill_cnt_next = fill_cnt_reg - ONE_C;
      default: fill_cnt_next = fill_cnt_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_cnt_reg     <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
    end else begin
      fill_cnt_reg     <= fill_cnt_next;
      full_reg         <= (fill_cnt_next == DEPTH_C);
      empty_reg        <= (fill_cnt_next == '0);
      almost_full_reg  <= (fill_cnt_next >= AFULL_C);
      almost_empty_reg <= (fill_cnt_next <= AEMPTY_C);
    end
  end

  assign fill_cnt     = fill_cnt_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;

`ifdef VFIFO_ERR_FLAGS_EN
  // ---------------------------------------------------------------------------
  // Sticky misuse flags: set on a refused request, cleared only by reset.
  // ---------------------------------------------------------------------------
  logic ovf_err_reg;
  logic udf_err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_err_reg <= 1'b0;
      udf_err_reg <= 1'b0;
    end else begin
      if (wr_en && full_reg) begin
        ovf_err_reg <= 1'b1;
      end
      if (rd_en && empty_reg) begin
        udf_err_reg <= 1'b1;
      end
    end
  end

  assign ovf_err = ovf_err_reg;
  assign udf_err = udf_err_reg;
`endif

endmodule

// File: tb/tb_vfifo_sc_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vfifo_sc_fifo_ctrl
// Directed bench for the FIFO controller at ADDR_WIDTH=2, with a behavioural
// registered-address RAM attached so the first-word-fall-through output can be
// observed. A queue-based reference is compared on every falling edge, and
// hand-computed literals pin the key points of the sequence.
// -----------------------------------------------------------------------------
module tb_vfifo_sc_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [7:0]    d_a   = 8'h00;

  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   fill_cnt;
  logic [AW-1:0] adr_a;
  logic          we_a;
  logic [AW-1:0] adr_b;
`ifdef VFIFO_ERR_FLAGS_EN
  logic          ovf_err;
  logic          udf_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vfifo_sc_fifo_ctrl #(
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fill_cnt     (fill_cnt),
    .adr_a        (adr_a),
    .we_a         (we_a),
    .adr_b        (adr_b)
`ifdef VFIFO_ERR_FLAGS_EN
    ,
    .ovf_err      (ovf_err),
    .udf_err      (udf_err)
`endif
  );

  // Behavioural RAM: synchronous write, registered read address.
  logic [7:0]    ram [DEPTH];
  logic [AW-1:0] adr_b_q = '0;
  logic [7:0]    q_b;

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (we_a) ram[adr_a] <= d_a;
    adr_b_q <= adr_b;
  end
  assign q_b = ram[adr_b_q];

  // Reference: a queue of stored words plus totals of accepted pushes/pops.
  byte unsigned mq[$];
  int unsigned  m_wr  = 0;
  int unsigned  m_rd  = 0;
  bit           m_ovf = 1'b0;
  bit           m_udf = 1'b0;
  bit           m_wa;
  bit           m_ra;
  byte unsigned m_junk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_wr  = 0;
      m_rd  = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_wa = wr_en && (mq.size() < DEPTH);
      m_ra = rd_en && (mq.size() > 0);
      if (wr_en && !m_wa) m_ovf = 1'b1;
      if (rd_en && !m_ra) m_udf = 1'b1;
      if (m_ra) begin
        m_junk = mq.pop_front();
        m_rd++;
      end
      if (m_wa) begin
        mq.push_back(d_a);
        m_wr++;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the reference, away from the rising edge.
  int sz;
  always @(negedge clk) begin
    sz = mq.size();
    chk("empty",        int'(empty),        int'(sz == 0));
    chk("full",         int'(full),         int'(sz == DEPTH));
    chk("almost_full",  int'(almost_full),  int'(sz >= DEPTH - 2));
    chk("almost_empty", int'(almost_empty), int'(sz <= 2));
    chk("fill_cnt",     int'(fill_cnt),     sz);
    chk("we_a",         int'(we_a),         int'(wr_en && rst && (sz < DEPTH)));
    chk("adr_a",        int'(adr_a),        int'(m_wr % DEPTH));
    chk("adr_b",        int'(adr_b),        int'((m_rd + ((rd_en && sz > 0) ? 1 : 0)) % DEPTH));
    if (sz > 0) chk("q_b_head", int'(q_b), int'(mq[0]));
`ifdef VFIFO_ERR_FLAGS_EN
    chk("ovf_err", int'(ovf_err), int'(m_ovf));
    chk("udf_err", int'(udf_err), int'(m_udf));
`endif
  end

  // One clock of stimulus; inputs return idle shortly after the edge.
  task automatic cyc(input bit w, input bit r, input logic [7:0] d);
    wr_en = w;
    rd_en = r;
    d_a   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    $display("cyc t=%0t wr=%0b rd=%0b d=%02h -> fill=%0d empty=%0b full=%0b q_b=%02h",
             $time, w, r, d, fill_cnt, empty, full, q_b);
  endtask

  logic [7:0] exp_pop [4];

  initial begin
    exp_pop[0] = 8'h11;
    exp_pop[1] = 8'h22;
    exp_pop[2] = 8'h33;
    exp_pop[3] = 8'h44;

    // 1: reset values, then a single write
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty",   int'(empty),        1);
    chk("rst_full",    int'(full),         0);
    chk("rst_fill",    int'(fill_cnt),     0);
    chk("rst_aempty",  int'(almost_empty), 1);
    chk("rst_adr_b",   int'(adr_b),        0);
`ifdef VFIFO_ERR_FLAGS_EN
    chk("rst_ovf", int'(ovf_err), 0);
    chk("rst_udf", int'(udf_err), 0);
`endif
    #2 rst = 1'b1;
    cyc(1'b1, 1'b0, 8'hA5);
    chk("t1_empty", int'(empty),    0);
    chk("t1_fill",  int'(fill_cnt), 1);
    chk("t1_q_b",   int'(q_b),      8'hA5);
    cyc(1'b0, 1'b1, 8'h00);
    chk("t1_pop_empty", int'(empty), 1);

    // 2: fill to full, then a refused write
    cyc(1'b1, 1'b0, 8'h11);
    cyc(1'b1, 1'b0, 8'h22);
    cyc(1'b1, 1'b0, 8'h33);
    cyc(1'b1, 1'b0, 8'h44);
    chk("t2_full",  int'(full),        1);
    chk("t2_fill",  int'(fill_cnt),    4);
    chk("t2_afull", int'(almost_full), 1);
    wr_en = 1'b1;
    d_a   = 8'h55;
    #1;
    chk("t2_we_a_blocked", int'(we_a), 0);
    cyc(1'b1, 1'b0, 8'h55);
    chk("t2_fill_after_ovf", int'(fill_cnt), 4);
    chk("t2_head_after_ovf", int'(q_b),      8'h11);
`ifdef VFIFO_ERR_FLAGS_EN
    chk("t2_ovf_err", int'(ovf_err), 1);
`endif

    // 3: drain back-to-back, then an extra pop
    for (int i = 0; i < 4; i++) begin
      chk("t3_pop_q_b", int'(q_b), int'(exp_pop[i]));
      cyc(1'b0, 1'b1, 8'h00);
    end
    chk("t3_empty", int'(empty), 1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("t3_fill_after_udf", int'(fill_cnt), 0);
`ifdef VFIFO_ERR_FLAGS_EN
    chk("t3_udf_err", int'(udf_err), 1);
`endif

    // 4: steady push+pop at depth 2; write pointer wraps past the top
    cyc(1'b1, 1'b0, 8'h60);
    cyc(1'b1, 1'b0, 8'h61);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 8'(8'h62 + i));
      chk("t4_fill_hold", int'(fill_cnt), 2);
    end
    chk("t4_head", int'(q_b), 8'h6A);

    // 5: simultaneous push+pop at full, then at empty
    cyc(1'b1, 1'b0, 8'h70);
    cyc(1'b1, 1'b0, 8'h71);
    chk("t5_full", int'(full), 1);
    cyc(1'b1, 1'b1, 8'h72);
    chk("t5_fill_full_both", int'(fill_cnt), 3);
    chk("t5_head_full_both", int'(q_b),      8'h6B);
    repeat (3) cyc(1'b0, 1'b1, 8'h00);
    chk("t5_empty", int'(empty), 1);
    cyc(1'b1, 1'b1, 8'h80);
    chk("t5_fill_empty_both", int'(fill_cnt), 1);
    chk("t5_q_b_empty_both",  int'(q_b),      8'h80);

    // 6: asynchronous reset in the middle of a cycle
    cyc(1'b1, 1'b0, 8'h81);
    cyc(1'b1, 1'b0, 8'h82);
    chk("t6_fill_pre", int'(fill_cnt), 3);
    wr_en = 1'b1;
    d_a   = 8'h99;
    #2 rst = 1'b0;
    #1;
    chk("t6_empty",  int'(empty),        1);
    chk("t6_full",   int'(full),         0);
    chk("t6_fill",   int'(fill_cnt),     0);
    chk("t6_aempty", int'(almost_empty), 1);
    chk("t6_afull",  int'(almost_full),  0);
    chk("t6_adr_a",  int'(adr_a),        0);
    chk("t6_adr_b",  int'(adr_b),        0);
    chk("t6_we_a",   int'(we_a),         0);
`ifdef VFIFO_ERR_FLAGS_EN
    chk("t6_ovf", int'(ovf_err), 0);
    chk("t6_udf", int'(udf_err), 0);
`endif
    wr_en = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    cyc(1'b1, 1'b0, 8'hC3);
    chk("t6_post_fill", int'(fill_cnt), 1);
    chk("t6_post_q_b",  int'(q_b),      8'hC3);
    cyc(1'b0, 1'b1, 8'h00);
    chk("t6_post_empty", int'(empty), 1);
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
